pixel_line_ctrl: RTL and testbench

Pixel-clock-domain line controller directly downstream of the RAW8 payload unpacker.
- Generates the FIFO read enable that drains one line of H_ACTIVE pixels per line-start event.
- Re-times the unpacked pixel bytes and qualifying valid into a parallel video stream (pixel, de, lv, fv).
- Tracks line count within a frame and flags underflow and protocol errors for debug.

---
 rtl/pixel_line_ctrl_pkg.sv | 20 ++
 rtl/pixel_out_reg.sv | 58 +++++
 rtl/pixel_line_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pixel_line_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_line_ctrl_pkg.sv
// Shared types and constants for the pixel-domain line controller.
// The optional zero-padding path is enabled by defining PIXEL_LINE_CTRL_PAD_EN.
package pixel_line_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFrame,
    StFill,
    StRead,
    StHblank
  } line_state_e;

  // Consecutive empty READ cycles tolerated before padding the rest of the line.
  localparam int unsigned PAD_TIMEOUT = 64;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// Output retiming: registers FIFO data/valid into pix_data/de and derives lv,
// which stays high from the first to the last data enable of a line.
module pixel_out_reg
  import pixel_line_ctrl_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned H_ACTIVE    = 1920
) (
  input  logic                   pixel_clk_i,
  input  logic                   pixel_rst_i,
  input  logic [PIXEL_WIDTH-1:0] pix_data_i,
  input  logic                   pix_valid_i,
  input  logic                   pad_valid_i,
  output logic [PIXEL_WIDTH-1:0] pix_data_o,
  output logic                   de_o,
  output logic                   lv_o
);

  localparam int unsigned CntW = cnt_width(H_ACTIVE);
  localparam logic [CntW-1:0] LineLen = CntW'(H_ACTIVE);

  logic [PIXEL_WIDTH-1:0] data_q, data_d;
  logic                   de_q, de_d;
  logic                   lv_q, lv_d;
  logic [CntW-1:0]        de_cnt_q, de_cnt_d;

  always_comb begin
    de_d   = pix_valid_i | pad_valid_i;
    data_d = pix_valid_i ? pix_data_i : '0;
    // A full line of enables has been emitted: lv drops unless a new line begins.
    if (de_cnt_q == LineLen) begin
      de_cnt_d = de_d ? CntW'(1) : '0;
      lv_d     = de_d;
    end else begin
      de_cnt_d = de_cnt_q + CntW'(de_d);
      lv_d     = de_d | lv_q;
    end
  end

  always_ff @(posedge pixel_clk_i or posedge pixel_rst_i) begin
    if (pixel_rst_i) begin
      data_q   <= '0;
      de_q     <= 1'b0;
      lv_q     <= 1'b0;
      de_cnt_q <= '0;
    end else begin
      data_q   <= data_d;
      de_q     <= de_d;
      lv_q     <= lv_d;
      de_cnt_q <= de_cnt_d;
    end
  end

  assign pix_data_o = data_q;
  assign de_o       = de_q;
  assign lv_o       = lv_q;

endmodule

// File: rtl/pixel_line_ctrl.sv
// Line controller: drains H_ACTIVE pixels per line_start from the unpacker FIFO.
// Define PIXEL_LINE_CTRL_PAD_EN to zero-pad a line after a long FIFO underflow.
module pixel_line_ctrl
  import pixel_line_ctrl_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned H_ACTIVE    = 1920,
  parameter int unsigned HBLANK_MIN  = 16,
  parameter int unsigned LINE_CNT_W  = 12
) (
  input  logic                   pixel_clk_i,
  input  logic                   pixel_rst_i,
  input  logic                   frame_start_i,
  input  logic                   frame_end_i,
  input  logic                   line_start_i,
  input  logic                   fifo_empty_i,
  input  logic [PIXEL_WIDTH-1:0] pix_data_i,
  input  logic                   pix_valid_i,
  output logic                   rd_en_o,
  output logic [PIXEL_WIDTH-1:0] pix_data_o,
  output logic                   de_o,
  output logic                   lv_o,
  output logic                   fv_o,
  output logic [LINE_CNT_W-1:0]  line_cnt_o,
  output logic                   underflow_o,
  output logic                   proto_err_o
);

  localparam int unsigned PixCntW   = cnt_width(H_ACTIVE);
  localparam int unsigned BlankCntW = cnt_width(HBLANK_MIN);
  localparam logic [PixCntW-1:0]   LastPix   = PixCntW'(H_ACTIVE - 1);
  localparam logic [BlankCntW-1:0] BlankLoad = BlankCntW'(HBLANK_MIN);

  line_state_e            state_q;
  logic [PixCntW-1:0]     pix_cnt_q;
  logic [BlankCntW-1:0]   blank_cnt_q;
  logic                   fe_pend_q;
  logic                   fv_q;
  logic [LINE_CNT_W-1:0]  line_cnt_q;
  logic                   underflow_q;
  logic                   proto_err_q;
  logic                   pad_vld_q;
  logic                   pad_mode;
  logic                   pad_pix;
  logic                   rd_en;
  logic                   take_pix;
  logic                   in_line;
  logic                   fe_exit;

  assign in_line  = (state_q == StFill) || (state_q == StRead) || (state_q == StHblank);
  assign rd_en    = (state_q == StRead) && !fifo_empty_i && !pad_mode;
  assign take_pix = rd_en | pad_pix;
  assign fe_exit  = fe_pend_q | frame_end_i;

`ifdef PIXEL_LINE_CTRL_PAD_EN
  localparam int unsigned RunW = cnt_width(PAD_TIMEOUT);

  logic [RunW-1:0] empty_run_q;
  logic            pad_mode_q;

  // Once padding starts it owns the rest of the line, even if data reappears.
  always_ff @(posedge pixel_clk_i or posedge pixel_rst_i) begin
    if (pixel_rst_i) begin
      empty_run_q <= '0;
      pad_mode_q  <= 1'b0;
    end else if (state_q != StRead) begin
      empty_run_q <= '0;
      pad_mode_q  <= 1'b0;
    end else if (!pad_mode_q) begin
      if (!fifo_empty_i) begin
        empty_run_q <= '0;
      end else if (empty_run_q == RunW'(PAD_TIMEOUT - 1)) begin
        pad_mode_q <= 1'b1;
      end else begin
        empty_run_q <= empty_run_q + RunW'(1);
      end
    end
  end

  assign pad_mode = pad_mode_q;
  assign pad_pix  = (state_q == StRead) && pad_mode_q;
`else
  assign pad_mode = 1'b0;
  assign pad_pix  = 1'b0;
`endif

  always_ff @(posedge pixel_clk_i or posedge pixel_rst_i) begin
    if (pixel_rst_i) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      blank_cnt_q <= '0;
      fe_pend_q   <= 1'b0;
      fv_q        <= 1'b0;
      line_cnt_q  <= '0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
      pad_vld_q   <= 1'b0;
    end else begin
      // Delay pad strobes by one cycle to match the FIFO read latency.
      pad_vld_q <= pad_pix;
      if ((frame_start_i && (state_q != StIdle)) || (line_start_i && in_line)) begin
        proto_err_q <= 1'b1;
      end
      if (frame_end_i && in_line) begin
        fe_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_start_i) begin
            state_q     <= StFrame;
            fv_q        <= 1'b1;
            line_cnt_q  <= '0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
            fe_pend_q   <= 1'b0;
          end
        end
        StFrame: begin
          if (line_start_i) begin
            state_q   <= StFill;
            pix_cnt_q <= '0;
            fe_pend_q <= frame_end_i;
          end else if (frame_end_i) begin
            state_q <= StIdle;
            fv_q    <= 1'b0;
          end
        end
        StFill: begin
          if (!fifo_empty_i) begin
            state_q <= StRead;
          end
        end
        StRead: begin
          if (fifo_empty_i) begin
            underflow_q <= 1'b1;
          end
          if (take_pix) begin
            if (pix_cnt_q == LastPix) begin
              state_q     <= StHblank;
              pix_cnt_q   <= '0;
              blank_cnt_q <= BlankLoad;
              line_cnt_q  <= line_cnt_q + LINE_CNT_W'(1);
            end else begin
              pix_cnt_q <= pix_cnt_q + PixCntW'(1);
            end
          end
        end
        StHblank: begin
          if (blank_cnt_q == BlankCntW'(1)) begin
            state_q   <= fe_exit ? StIdle : StFrame;
            fv_q      <= !fe_exit;
            fe_pend_q <= 1'b0;
          end else begin
            blank_cnt_q <= blank_cnt_q - BlankCntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pixel_out_reg #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .H_ACTIVE    (H_ACTIVE)
  ) u_out_reg (
    .pixel_clk_i (pixel_clk_i),
    .pixel_rst_i (pixel_rst_i),
    .pix_data_i  (pix_data_i),
    .pix_valid_i (pix_valid_i),
    .pad_valid_i (pad_vld_q),
    .pix_data_o  (pix_data_o),
    .de_o        (de_o),
    .lv_o        (lv_o)
  );

  assign rd_en_o     = rd_en;
  assign fv_o        = fv_q;
  assign line_cnt_o  = line_cnt_q;
  assign underflow_o = underflow_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_pixel_line_ctrl.sv
// Bench for pixel_line_ctrl with an 8-pixel line: a stream-level scoreboard plus
// directed line scenarios (normal, frame end, underflow, protocol error, reset, padding).
module tb_pixel_line_ctrl;

  localparam int unsigned HA = 8;
  localparam int unsigned HB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        line_start = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_valid = 1'b0;
  logic        rd_en, de, lv, fv, underflow, proto_err;
  logic [7:0]  pix_out;
  logic [11:0] line_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  pixel_line_ctrl #(
    .PIXEL_WIDTH (8),
    .H_ACTIVE    (HA),
    .HBLANK_MIN  (HB),
    .LINE_CNT_W  (12)
  ) dut (
    .pixel_clk_i   (clk),
    .pixel_rst_i   (rst),
    .frame_start_i (frame_start),
    .frame_end_i   (frame_end),
    .line_start_i  (line_start),
    .fifo_empty_i  (fifo_empty),
    .pix_data_i    (pix_data),
    .pix_valid_i   (pix_valid),
    .rd_en_o       (rd_en),
    .pix_data_o    (pix_out),
    .de_o          (de),
    .lv_o          (lv),
    .fv_o          (fv),
    .line_cnt_o    (line_cnt),
    .underflow_o   (underflow),
    .proto_err_o   (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: bytes are stored in ascending order from 0x10; data appears one cycle after rd_en.
  logic [7:0] fifo_byte = 8'h10;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd_en;
      if (rd_en) begin
        pix_data  <= fifo_byte;
        fifo_byte <= fifo_byte + 8'd1;
      end else begin
        pix_data <= 8'hEE;
      end
    end
  end

  // Scoreboard: the output stream must be the FIFO contents in order (or zeros once a
  // line is being padded), H_ACTIVE enables per lv window, de trailing rd_en by 2 cycles.
  int         pad_from = -1;
  logic       stats_clr = 1'b0;
  logic [7:0] exp_next = 8'h10;
  int         line_de = 0;
  logic       rd_h1 = 1'b0, rd_h2 = 1'b0, lv_prev = 1'b0, seen_fall = 1'b0;
  int         low_run = 0;
  int         lv_fall_cnt = 0;
  int         rd_n = 0, de_n = 0, rd_first = -1, rd_last = -1, de_first = -1, de_last = -1;
  int         lv_hi_n = 0;
  logic [7:0] de_first_data = 8'h00, de_last_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rd_h1     <= 1'b0;
      rd_h2     <= 1'b0;
      lv_prev   <= 1'b0;
      seen_fall <= 1'b0;
      line_de   <= 0;
      low_run   <= 0;
      exp_next  <= fifo_byte;
    end else begin
      rd_h1   <= rd_en;
      rd_h2   <= rd_h1;
      lv_prev <= lv;
      if (fifo_empty) check("rd_en_while_empty", rd_en, 1'b0);
      check("de_without_lv", de & ~lv, 1'b0);
      if (pad_from < 0 || line_de < pad_from) check("de_latency", de, rd_h2);
      if (!de) begin
        check("data_zero_without_de", pix_out, 8'h00);
      end else if (pad_from >= 0 && line_de >= pad_from) begin
        check("pad_pixel", pix_out, 8'h00);
        line_de <= line_de + 1;
      end else begin
        check("pixel", pix_out, exp_next);
        exp_next <= exp_next + 8'd1;
        line_de  <= line_de + 1;
      end
      if (lv_prev && !lv) begin
        check("line_length", line_de, HA);
        line_de     <= 0;
        lv_fall_cnt <= lv_fall_cnt + 1;
        seen_fall   <= 1'b1;
      end
      if (!lv_prev && lv && seen_fall) check("hblank_gap_ok", low_run >= HB, 1'b1);
      low_run <= lv ? 0 : low_run + 1;
      if (stats_clr) begin
        rd_n <= 0; de_n <= 0; lv_hi_n <= 0;
        rd_first <= -1; rd_last <= -1; de_first <= -1; de_last <= -1;
      end else begin
        if (rd_en) begin
          rd_n <= rd_n + 1;
          if (rd_first < 0) rd_first <= cyc;
          rd_last <= cyc;
        end
        if (de) begin
          de_n <= de_n + 1;
          if (de_first < 0) begin
            de_first      <= cyc;
            de_first_data <= pix_out;
          end
          de_last      <= cyc;
          de_last_data <= pix_out;
        end
        if (lv) lv_hi_n <= lv_hi_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (rd_n >= n) done = 1'b1;
    end
    check("wait_rd_timeout", done, 1'b1);
  endtask

  task automatic wait_line(input int budget);
    int  base;
    bit  done;
    base = lv_fall_cnt;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (lv_fall_cnt != base) done = 1'b1;
    end
    check("line_end_timeout", done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_lv"}, lv, 1'b0);
    check({tag, "_fv"}, fv, 1'b0);
    check({tag, "_line_cnt"}, line_cnt, 12'd0);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_proto_err"}, proto_err, 1'b0);
    check({tag, "_pix_data"}, pix_out, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: single clean line, bytes 0x10..0x17
    pulse_fs();
    check("t1_fv_rise", fv, 1'b1);
    check("t1_line_cnt_start", line_cnt, 12'd0);
    clear_stats();
    pulse_ls();
    wait_line(60);
    check("t1_rd_count", rd_n, HA);
    check("t1_rd_span", rd_last - rd_first + 1, HA);
    check("t1_de_count", de_n, HA);
    check("t1_de_after_rd", de_first - rd_first, 2);
    check("t1_first_pixel", de_first_data, 8'h10);
    check("t1_last_pixel", de_last_data, 8'h17);
    check("t1_lv_width", lv_hi_n, HA);
    idle(HB + 2);
    check("t1_line_cnt", line_cnt, 12'd1);
    check("t1_underflow", underflow, 1'b0);
    check("t1_proto_err", proto_err, 1'b0);

    // 2: lines 2 and 3, frame_end during line 3 READ
    clear_stats();
    pulse_ls();
    wait_line(60);
    idle(HB + 2);
    check("t2_line2_de", de_n, HA);
    check("t2_line_cnt2", line_cnt, 12'd2);
    clear_stats();
    pulse_ls();
    wait_rd(4, 40);
    pulse_fe();
    wait_line(60);
    check("t2_fv_held", fv, 1'b1);
    idle(HB + 2);
    check("t2_line3_rd", rd_n, HA);
    check("t2_line3_de", de_n, HA);
    check("t2_fv_fall", fv, 1'b0);
    check("t2_line_cnt3", line_cnt, 12'd3);
    clear_stats();
    pulse_ls();
    idle(20);
    check("t2_idle_ls_no_read", rd_n, 0);
    check("t2_idle_ls_no_err", proto_err, 1'b0);

    // 3: three-cycle underflow mid-line
    pulse_fs();
    check("t3_line_cnt_clr", line_cnt, 12'd0);
    clear_stats();
    pulse_ls();
    wait_rd(3, 40);
    fifo_empty = 1'b1;
    idle(3);
    fifo_empty = 1'b0;
    wait_line(60);
    check("t3_rd_count", rd_n, HA);
    check("t3_rd_span", rd_last - rd_first + 1, HA + 3);
    check("t3_de_count", de_n, HA);
    check("t3_lv_width", lv_hi_n, HA + 3);
    check("t3_underflow", underflow, 1'b1);
    check("t3_proto_err", proto_err, 1'b0);
    idle(HB + 2);
    check("t3_line_cnt", line_cnt, 12'd1);

    // 4: line_start during READ is ignored and flagged
    clear_stats();
    pulse_ls();
    wait_rd(3, 40);
    pulse_ls();
    check("t4_proto_err", proto_err, 1'b1);
    wait_line(60);
    idle(HB + 20);
    check("t4_rd_count", rd_n, HA);
    check("t4_de_count", de_n, HA);
    check("t4_line_cnt", line_cnt, 12'd2);

    // 5: reset mid-line, then a clean line
    clear_stats();
    pulse_ls();
    wait_rd(4, 40);
    rst = 1'b1;
    #1;
    check_all_zero("t5_abort");
    idle(2);
    rst = 1'b0;
    idle(10);
    check("t5_no_rd_after_reset", rd_n, 4);
    pulse_fs();
    clear_stats();
    pulse_ls();
    wait_line(60);
    check("t5_rd_count", rd_n, HA);
    check("t5_rd_span", rd_last - rd_first + 1, HA);
    check("t5_de_count", de_n, HA);
    idle(HB + 2);
    check("t5_line_cnt", line_cnt, 12'd1);
    check("t5_proto_err", proto_err, 1'b0);
    check("t5_underflow", underflow, 1'b0);

`ifdef PIXEL_LINE_CTRL_PAD_EN
    // 6: FIFO dries up after pixel 5; the rest of the line is zero-padded
    pad_from = 5;
    clear_stats();
    pulse_ls();
    wait_rd(5, 40);
    fifo_empty = 1'b1;
    wait_line(200);
    fifo_empty = 1'b0;
    pad_from = -1;
    check("t6_rd_count", rd_n, 5);
    check("t6_de_count", de_n, HA);
    check("t6_de_span", de_last - de_first, 71);
    check("t6_lv_width", lv_hi_n, 72);
    check("t6_underflow", underflow, 1'b1);
    idle(HB + 2);
    check("t6_line_cnt", line_cnt, 12'd2);
`endif

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
